// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity mode constants,
// used by uart_tx and later by uart_rx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY_BIT = 3'd3,
    STOP       = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter with a one-deep holding register. The line advances one
// bit per clk_tick; a byte waiting in the holding register when the last stop
// bit ends is started immediately, with no idle bit in between.
//
// Handshake: a byte is taken on a rising clk edge where in_valid and in_ready
// are both 1. in_ready is a register with no path from in_valid. It drops on
// the accepting edge, stays low while the holding register is full, and rises
// one edge after the byte moves into the shift register.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clk_tick,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  // One counter serves both the data phase and the stop phase.
  localparam int MAX_BITS = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
  localparam int CNT_W    = $clog2(MAX_BITS);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 full_q, full_d;
  logic                 in_ready_q, in_ready_d;
  logic                 tx_q, tx_d;
  logic                 par_q, par_d;
  logic                 accept;
  logic                 load;

  // Holding register, full flag and the registered ready signal.
  always_comb begin
    accept     = in_valid & in_ready_q;
    full_d     = full_q;
    hold_d     = hold_q;
    if (load) full_d = 1'b0;
    if (accept) begin
      full_d = 1'b1;
      hold_d = in_data;
    end
    in_ready_d = ~full_q & ~accept;
  end

  // Frame sequencer: next state, next line value and the shift/count updates.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    par_d   = par_q;
    load    = 1'b0;
    if (clk_tick) begin
      case (state_q)
        IDLE: begin
          if (full_q) begin
            load    = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
          end
        end
        START: begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
        end
        DATA: begin
          if (cnt_q == LAST_DATA) begin
            cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = PARITY_BIT;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
        PARITY_BIT: begin
          state_d = STOP;
          tx_d    = 1'b1;
          cnt_d   = '0;
        end
        STOP: begin
          if (cnt_q == LAST_STOP) begin
            cnt_d = '0;
            if (full_q) begin
              load    = 1'b1;
              state_d = START;
              tx_d    = 1'b0;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end
    // Parity is taken from the whole byte at load time, so it does not
    // depend on how far the shift register has advanced.
    if (load) begin
      shift_d = hold_q;
      par_d   = (PARITY == PAR_ODD) ? ~(^hold_q) : (^hold_q);
    end
  end

  // State registers; reset aborts the frame and drops any held byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      in_ready_q <= 1'b1;
      tx_q       <= 1'b1;
      par_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      full_q     <= full_d;
      in_ready_q <= in_ready_d;
      tx_q       <= tx_d;
      par_q      <= par_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (default, even parity, odd
// parity, two stop bits) share clock, tick and inputs; each step checks the
// instance it targets against hand-computed line sequences.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk_tick = 1'b0;
  logic       tick_en = 1'b1;
  logic [1:0] div = 2'd0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;

  logic d_rdy, d_tx, d_busy, e_rdy, e_tx, e_busy;
  logic o_rdy, o_tx, o_busy, s_rdy, s_tx, s_busy;
  logic [2:0] d_st, e_st, o_st, s_st;

  int total = 0;
  int bad   = 0;

  // clock / tick block
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (!tick_en) begin
      div      <= 2'd0;
      clk_tick <= 1'b0;
    end else begin
      div      <= div + 2'd1;
      clk_tick <= (div == 2'd3);
    end
  end

  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_def (
    .clk(clk), .reset_n(reset_n), .clk_tick(clk_tick), .in_data(in_data),
    .in_valid(in_valid), .in_ready(d_rdy), .tx(d_tx), .busy(d_busy), .dbg_state(d_st));
  uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .reset_n(reset_n), .clk_tick(clk_tick), .in_data(in_data),
    .in_valid(in_valid), .in_ready(e_rdy), .tx(e_tx), .busy(e_busy), .dbg_state(e_st));
  uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .reset_n(reset_n), .clk_tick(clk_tick), .in_data(in_data),
    .in_valid(in_valid), .in_ready(o_rdy), .tx(o_tx), .busy(o_busy), .dbg_state(o_st));
  uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .reset_n(reset_n), .clk_tick(clk_tick), .in_data(in_data),
    .in_valid(in_valid), .in_ready(s_rdy), .tx(s_tx), .busy(s_busy), .dbg_state(s_st));

  // scoreboard
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic next_tick();
    int  n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    do begin
      @(posedge clk);
      n++;
      seen = clk_tick;
    end while (!seen && n < 16);
    #1;
    if (!seen) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    check("rst_tx", 32'(d_tx), 32'd1);
    check("rst_busy", 32'(d_busy), 32'd0);
    check("rst_rdy", 32'(d_rdy), 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Offer one byte at a negedge; it is taken on the following posedge.
  task automatic send_byte(input logic [7:0] b, input string tag);
    @(negedge clk);
    check({tag, "_rdy_before"}, 32'(d_rdy), 32'd1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_rdy_after"}, 32'(d_rdy), 32'd0);
  endtask

  logic s55  [10] = '{0,1,0,1,0,1,0,1,0,1};
  logic sb2b [20] = '{0,1,1,0,0,0,1,0,1,1, 0,1,1,1,1,0,0,0,0,1};
  logic sev  [11] = '{0,1,1,1,0,0,0,0,0,1,1};
  logic sod  [11] = '{0,1,1,1,0,0,0,0,0,0,1};
  logic s00  [11] = '{0,0,0,0,0,0,0,0,0,1,1};
  logic s81  [10] = '{0,1,0,0,0,0,0,0,1,1};
  logic s3c  [10] = '{0,0,0,1,1,1,1,0,0,1};

  initial begin
    // single byte 0x55, accepted on an edge that is also a tick edge
    do_reset();
    do begin @(negedge clk); #1; end while (!clk_tick);
    in_data  = 8'h55;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("t1_no_start_on_accept_tick", 32'(d_busy), 32'd0);
    check("t1_tx_idle", 32'(d_tx), 32'd1);
    check("t1_rdy_low", 32'(d_rdy), 32'd0);
    for (int i = 0; i < 10; i++) begin
      next_tick();
      check($sformatf("t1_tx%0d", i), 32'(d_tx), 32'(s55[i]));
      check($sformatf("t1_busy%0d", i), 32'(d_busy), 32'd1);
    end
    next_tick();
    check("t1_end_tx", 32'(d_tx), 32'd1);
    check("t1_end_busy", 32'(d_busy), 32'd0);
    check("t1_end_rdy", 32'(d_rdy), 32'd1);

    // back-to-back 0xA3 then 0x0F offered during DATA
    do_reset();
    send_byte(8'hA3, "t2a");
    for (int i = 0; i < 20; i++) begin
      next_tick();
      check($sformatf("t2_tx%0d", i), 32'(d_tx), 32'(sb2b[i]));
      check($sformatf("t2_busy%0d", i), 32'(d_busy), 32'd1);
      if (i == 1) send_byte(8'h0F, "t2b");
      if (i >= 2 && i <= 10) check($sformatf("t2_rdy%0d", i), 32'(d_rdy), 32'd0);
      if (i == 10) begin
        @(posedge clk);
        #1;
        check("t2_rdy_rise", 32'(d_rdy), 32'd1);
      end
    end
    next_tick();
    check("t2_end_tx", 32'(d_tx), 32'd1);
    check("t2_end_busy", 32'(d_busy), 32'd0);

    // parity: 0x07 -> even parity bit 1, odd parity bit 0, 11 ticks
    do_reset();
    send_byte(8'h07, "t3");
    for (int i = 0; i < 11; i++) begin
      next_tick();
      check($sformatf("t3_even_tx%0d", i), 32'(e_tx), 32'(sev[i]));
      check($sformatf("t3_odd_tx%0d", i), 32'(o_tx), 32'(sod[i]));
      check($sformatf("t3_even_busy%0d", i), 32'(e_busy), 32'd1);
    end
    next_tick();
    check("t3_even_end_busy", 32'(e_busy), 32'd0);
    check("t3_odd_end_busy", 32'(o_busy), 32'd0);

    // two stop bits with 0x00
    do_reset();
    send_byte(8'h00, "t4");
    for (int i = 0; i < 11; i++) begin
      next_tick();
      check($sformatf("t4_tx%0d", i), 32'(s_tx), 32'(s00[i]));
      check($sformatf("t4_busy%0d", i), 32'(s_busy), 32'd1);
    end
    next_tick();
    check("t4_end_busy", 32'(s_busy), 32'd0);
    check("t4_end_tx", 32'(s_tx), 32'd1);

    // reset during data bit 3 (tx low for 0x55), then 0x81
    do_reset();
    send_byte(8'h55, "t5a");
    for (int i = 0; i < 5; i++) next_tick();
    check("t5_pre_tx", 32'(d_tx), 32'd0);
    #4;
    reset_n = 1'b0;
    #1;
    check("t5_async_tx", 32'(d_tx), 32'd1);
    check("t5_async_busy", 32'(d_busy), 32'd0);
    check("t5_async_rdy", 32'(d_rdy), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_tick();
      check($sformatf("t5_idle_busy%0d", i), 32'(d_busy), 32'd0);
      check($sformatf("t5_idle_tx%0d", i), 32'(d_tx), 32'd1);
    end
    send_byte(8'h81, "t5b");
    for (int i = 0; i < 10; i++) begin
      next_tick();
      check($sformatf("t5_tx%0d", i), 32'(d_tx), 32'(s81[i]));
    end
    next_tick();
    check("t5_end_busy", 32'(d_busy), 32'd0);

    // stalled tick with in_valid held high
    do_reset();
    @(negedge clk);
    tick_en  = 1'b0;
    in_data  = 8'h3C;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rdy_first", 32'(d_rdy), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    check("t6_rdy_stall", 32'(d_rdy), 32'd0);
    check("t6_tx_stall", 32'(d_tx), 32'd1);
    check("t6_busy_stall", 32'(d_busy), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    tick_en  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      next_tick();
      check($sformatf("t6_tx%0d", i), 32'(d_tx), 32'(s3c[i]));
    end
    for (int i = 0; i < 2; i++) begin
      next_tick();
      check($sformatf("t6_after_busy%0d", i), 32'(d_busy), 32'd0);
      check($sformatf("t6_after_rdy%0d", i), 32'(d_rdy), 32'd1);
    end

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-002 SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits per frame, legal values 1 or 2.
REQ-004 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port clk_tick  input  1  one-clk-wide bit-period strobe, driven by the upstream clock divider.
REQ-007 SHALL have port in_data  input  DATA_BITS  byte to transmit.
REQ-008 SHALL have port in_valid  input  1  in_data is valid.
REQ-009 SHALL have port in_ready  output  1  holding register is empty and can accept a byte.
REQ-010 SHALL have port tx  output  1  serial line, idle high, registered.
REQ-011 SHALL have port busy  output  1  a frame is in progress (state != IDLE).

Function
REQ-012 SHALL accept a byte into a one-deep holding register on the rising clk edge where in_valid and in_ready are both 1.
REQ-013 SHALL drive in_ready as the registered inverse of the holding-register-full flag, with no combinational path from in_valid.
REQ-014 SHALL implement states IDLE, START, DATA, PARITY_BIT and STOP; all transitions occur only on edges where clk_tick = 1.
REQ-015 SHALL leave IDLE only on a clk_tick edge with the holding register full, then:
- load the shift register from the holding register;
- clear the full flag;
- enter START with tx = 0.
REQ-016 SHALL start a frame on the first clk_tick edge strictly after the accepting edge; a tick coincident with acceptance does not start it.
REQ-017 SHALL in DATA shift out LSB first, one bit per tick, for exactly DATA_BITS ticks.
REQ-018 SHALL, when PARITY != 0, send one parity bit after DATA:
- odd: XOR of the data bits, inverted;
- even: XOR of the data bits.
REQ-019 SHALL skip PARITY_BIT entirely when PARITY = 0.
REQ-020 SHALL hold tx = 1 in STOP for exactly STOP_BITS ticks.
REQ-021 SHALL, on the tick ending the last stop bit:
- if the holding register is full, go directly to START and load the next byte (no idle gap);
- otherwise go to IDLE.
REQ-022 SHALL make every frame exactly 1 + DATA_BITS + (PARITY != 0) + STOP_BITS ticks long, with each bit held for one full tick period.
REQ-023 SHALL make simultaneous accept and load impossible: in_ready is 0 on the loading edge and rises on the following edge.
REQ-024 SHALL keep all state and tx unchanged while clk_tick = 0, regardless of in_valid.

Reset
REQ-025 SHALL, while reset_n = 0, asynchronously force:
- tx = 1, busy = 0, in_ready = 1;
- holding register empty, state IDLE;
- bit counter 0, shift register 0.
REQ-026 SHALL abort any frame in progress on reset and discard the held byte; nothing is resumed after release.
REQ-027 SHALL resume normal acceptance on the first clk edge after reset_n deasserts.

Structure
REQ-028 SHALL take the state encoding and the PARITY encoding constants (PAR_NONE, PAR_ODD, PAR_EVEN) from shared package uart_pkg, for reuse by the future uart_rx.
REQ-029 SHALL contain no sub-module; the clock divider is instantiated beside it at top level and feeds clk_tick.
REQ-030 SHALL use a single bit counter sized for the largest of DATA_BITS and STOP_BITS.

Verification (bench: clk period 20, clk_tick pulsed 1 clk every 4 clks; defaults unless stated)
REQ-031 SHALL cover single byte: 0x55 -> tx per tick 0,1,0,1,0,1,0,1,0,1, then idle high; busy high for exactly 10 ticks.
REQ-032 SHALL cover back-to-back: 0xA3, then 0x0F offered during DATA ->
- 0x0F accepted on the next edge; in_ready low until 0x0F is loaded;
- stop bit of 0xA3 immediately followed by start bit of 0x0F, no idle tick.
REQ-033 SHALL cover parity: PARITY=2 with 0x07 -> parity bit 1; PARITY=1 with 0x07 -> parity bit 0; frame length 11 ticks.
REQ-034 SHALL cover two stop bits: STOP_BITS=2 with 0x00 -> tx low for 9 ticks, high for 2 ticks, then busy = 0.
REQ-035 SHALL cover reset mid-frame: reset_n low during data bit 3 -> tx = 1, busy = 0, in_ready = 1 immediately (no clk edge); next byte 0x81 after release transmits correctly.
REQ-036 SHALL cover stalled tick: clk_tick held 0 with in_valid held high -> exactly one accept, in_ready stays 0, tx stays 1, busy stays 0.
